food_placer: RTL and testbench

- Downstream consumer of the free-running random column/row values (ran_h 0..79, ran_v 0..59) in the snake game.
- On request from the game controller, it turns the current random pair into a legal food cell that is not occupied by the snake.
- It queries the occupancy grid RAM through a read port. If the start cell is occupied, it probes forward linearly, row-major with wrap, until it finds a free cell or the grid is exhausted.
- The result drives the food register read by the VGA renderer and the game FSM.

---
 rtl/food_placer_if.sv | 28 ++
 rtl/food_placer.sv | 116 +++++++++++
 tb/tb_food_placer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/food_placer_if.sv
// Controller/RAM/renderer bundle around the food placer.
// The placer connects through "slave"; the environment connects through "master".
interface food_placer_if #(
    parameter int ADDR_W = 13
);
    logic              req;
    logic [31:0]       ran_h;
    logic [31:0]       ran_v;
    logic              occ_rd_en;
    logic [ADDR_W-1:0] occ_addr;
    logic              occ_data;
    logic [6:0]        food_x;
    logic [5:0]        food_y;
    logic              food_valid;
    logic              busy;
    logic              done;
    logic              fail;

    modport slave (
        input  req, ran_h, ran_v, occ_data,
        output occ_rd_en, occ_addr, food_x, food_y, food_valid, busy, done, fail
    );

    modport master (
        output req, ran_h, ran_v, occ_data,
        input  occ_rd_en, occ_addr, food_x, food_y, food_valid, busy, done, fail
    );
endinterface

// File: rtl/food_placer.sv
// Turns the free-running random column/row into a free food cell, probing the
// occupancy RAM forward in row-major order with wrap until a free cell appears.
module food_placer #(
    parameter int H_CELLS    = 80,
    parameter int V_CELLS    = 60,
    parameter int ADDR_W     = 13,
    parameter int MAX_PROBES = 4800
) (
    input logic mclk,
    input logic rst,
    food_placer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_PROBES);

    typedef enum logic [1:0] {IDLE, READ, CHECK} state_t;

    state_t             state, state_n;
    logic [6:0]         cx, cx_n;
    logic [5:0]         cy, cy_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [6:0]         fx, fx_n;
    logic [5:0]         fy, fy_n;
    logic               fv, fv_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               fail_r, fail_n;
    logic [ADDR_W-1:0]  lin;

    assign lin = ADDR_W'(cy) * ADDR_W'(H_CELLS) + ADDR_W'(cx);

    assign bus.occ_rd_en  = (state == READ);
    assign bus.occ_addr   = (state == READ) ? lin : '0;
    assign bus.food_x     = fx;
    assign bus.food_y     = fy;
    assign bus.food_valid = fv;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.fail       = fail_r;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cx     <= '0;
            cy     <= '0;
            cnt    <= '0;
            fx     <= '0;
            fy     <= '0;
            fv     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            fail_r <= 1'b0;
        end else begin
            state  <= state_n;
            cx     <= cx_n;
            cy     <= cy_n;
            cnt    <= cnt_n;
            fx     <= fx_n;
            fy     <= fy_n;
            fv     <= fv_n;
            busy_r <= busy_n;
            done_r <= done_n;
            fail_r <= fail_n;
        end
    end

    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        cnt_n   = cnt;
        fx_n    = fx;
        fy_n    = fy;
        fv_n    = fv;
        busy_n  = busy_r;
        done_n  = 1'b0;
        fail_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    // Out-of-range random values fold to 0 rather than being clipped.
                    cx_n    = (bus.ran_h < 32'(H_CELLS)) ? bus.ran_h[6:0] : '0;
                    cy_n    = (bus.ran_v < 32'(V_CELLS)) ? bus.ran_v[5:0] : '0;
                    cnt_n   = '0;
                    fv_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = READ;
                end
            end
            READ: state_n = CHECK;
            CHECK: begin
                if (!bus.occ_data) begin
                    fx_n    = cx;
                    fy_n    = cy;
                    fv_n    = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt == CNT_W'(MAX_PROBES - 1)) begin
                    fail_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    state_n = READ;
                    if (cx == 7'(H_CELLS - 1)) begin
                        cx_n = '0;
                        cy_n = (cy == 6'(V_CELLS - 1)) ? '0 : cy + 6'd1;
                    end else begin
                        cx_n = cx + 7'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_food_placer.sv
// Randomized check of food_placer against a linear-index search model over a
// behavioural occupancy RAM with one-cycle read latency.
module tb_food_placer;
    logic mclk = 1'b0;
    logic rst  = 1'b1;
    always #5 mclk = ~mclk;

    food_placer_if bus ();
    food_placer dut (.mclk(mclk), .rst(rst), .bus(bus));

    bit          grid [4800];
    int          n_chk = 0, n_pass = 0;
    int          done_cnt = 0, fail_cnt = 0, both_cnt = 0;
    logic [12:0] addr_q [$];

    always @(posedge mclk) bus.occ_data <= bus.occ_rd_en ? grid[bus.occ_addr] : 1'b0;

    always @(negedge mclk) begin
        if (bus.occ_rd_en) addr_q.push_back(bus.occ_addr);
        if (bus.done) done_cnt++;
        if (bus.fail) fail_cnt++;
        if (bus.done && bus.fail) both_cnt++;
    end

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill(int dens);
        for (int i = 0; i < 4800; i++) grid[i] = (dens >= 8) ? 1'b1 : (($urandom % 8) < dens);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".fx"},   int'(bus.food_x), 0);
        chk({tag, ".fy"},   int'(bus.food_y), 0);
        chk({tag, ".fv"},   int'(bus.food_valid), 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
        chk({tag, ".done"}, int'(bus.done), 0);
        chk({tag, ".fail"}, int'(bus.fail), 0);
        chk({tag, ".rden"}, int'(bus.occ_rd_en), 0);
        chk({tag, ".addr"}, int'(bus.occ_addr), 0);
    endtask

    // dup_cyc > 0 injects a second req in that cycle, which must be ignored.
    task automatic run_case(string tag, logic [31:0] h, logic [31:0] v, int dup_cyc);
        int sx, sy, start, n, fx, fy, idx, cyc, nlow, nbad, d0, hx, hy;
        bit ok;
        sx = (h < 80) ? int'(h) : 0;
        sy = (v < 60) ? int'(v) : 0;
        start = sy * 80 + sx;
        ok = 1'b0; n = 4800; fx = 0; fy = 0;
        for (int i = 0; i < 4800; i++) begin
            idx = (start + i) % 4800;
            if (!grid[idx]) begin
                ok = 1'b1; n = i + 1; fx = idx % 80; fy = idx / 80;
                break;
            end
        end
        @(negedge mclk);
        addr_q.delete();
        d0 = done_cnt + fail_cnt;
        bus.ran_h = h; bus.ran_v = v; bus.req = 1'b1;
        @(negedge mclk);
        bus.req = 1'b0; bus.ran_h = $urandom; bus.ran_v = $urandom;
        cyc = 1; nlow = 0;
        while (!(bus.done || bus.fail) && cyc < 9700) begin
            if (!bus.busy) nlow++;
            if (cyc == dup_cyc) begin
                bus.req = 1'b1; bus.ran_h = 32'd3; bus.ran_v = 32'd3;
            end else bus.req = 1'b0;
            @(negedge mclk);
            cyc++;
        end
        bus.req = 1'b0;
        chk({tag, ".cyc"},  cyc, 2 * n + 1);
        chk({tag, ".done"}, int'(bus.done), int'(ok));
        chk({tag, ".fail"}, int'(bus.fail), int'(!ok));
        chk({tag, ".busy"}, int'(bus.busy), 0);
        chk({tag, ".fv"},   int'(bus.food_valid), int'(ok));
        if (ok) begin
            chk({tag, ".fx"}, int'(bus.food_x), fx);
            chk({tag, ".fy"}, int'(bus.food_y), fy);
        end
        chk({tag, ".busy_hi"}, nlow, 0);
        chk({tag, ".nrd"}, addr_q.size(), n);
        nbad = 0;
        for (int k = 0; k < addr_q.size() && k < n; k++)
            if (int'(addr_q[k]) != (start + k) % 4800) nbad++;
        chk({tag, ".addr_seq"}, nbad, 0);
        hx = int'(bus.food_x); hy = int'(bus.food_y);
        @(negedge mclk);
        chk({tag, ".pulse"}, int'(bus.done) + int'(bus.fail), 0);
        repeat (3) @(negedge mclk);
        chk({tag, ".hold_x"}, int'(bus.food_x), hx);
        chk({tag, ".hold_y"}, int'(bus.food_y), hy);
        chk({tag, ".npulse"}, done_cnt + fail_cnt - d0, 1);
    endtask

    initial begin
        int c0;
        bus.req = 1'b0; bus.ran_h = '0; bus.ran_v = '0;
        repeat (3) @(negedge mclk);
        chk_reset_vals("reset");
        rst = 1'b0;

        fill(0);
        run_case("empty", 32'd10, 32'd5, 0);
        grid[410] = 1; grid[411] = 1; grid[412] = 1;
        run_case("run3", 32'd10, 32'd5, 0);
        run_case("dupreq", 32'd10, 32'd5, 4);
        fill(0);
        grid[4799] = 1; grid[0] = 1;
        run_case("wrap", 32'd79, 32'd59, 0);
        fill(0);
        run_case("oor", 32'd85, 32'd70, 0);
        fill(8);
        run_case("full", 32'd20, 32'd30, 0);

        // Asynchronous reset during the third probe's read.
        fill(0);
        grid[0] = 1; grid[1] = 1; grid[2] = 1; grid[3] = 1; grid[4] = 1;
        run_case("pre_rst", 32'd0, 32'd0, 0);
        @(negedge mclk);
        c0 = done_cnt + fail_cnt;
        bus.req = 1'b1; bus.ran_h = 32'd0; bus.ran_v = 32'd0;
        repeat (5) @(negedge mclk) bus.req = 1'b0;
        chk("mid.rden3", int'(bus.occ_rd_en), 1);
        chk("mid.addr3", int'(bus.occ_addr), 2);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge mclk);
        rst = 1'b0;
        repeat (20) @(negedge mclk);
        chk("mid.nopulse", done_cnt + fail_cnt - c0, 0);
        chk("mid.busy", int'(bus.busy), 0);
        chk("mid.fv", int'(bus.food_valid), 0);

        for (int it = 0; it < 10; it++) begin
            fill(int'($urandom_range(0, 7)));
            run_case($sformatf("rnd%0d", it), 32'($urandom_range(0, 99)), 32'($urandom_range(0, 69)), 0);
        end

        chk("both_pulse", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
